// File: rtl/adda_pkg.sv
// Shared types and default sizing for the AN108 ADC/DAC to async SRAM recorder.
package adda_pkg;

  localparam int unsigned ADDR_W   = 18;
  localparam int unsigned SAMPLE_W = 8;
  localparam logic [7:0]  IDLE_CODE = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/adda_sram_recorder.sv
// Records the ADC byte stream into async SRAM (two samples per word) and plays
// it back to the DAC once or looped; SRAM is accessed every second cycle.
module adda_sram_recorder #(
  parameter int unsigned ADDR_W   = adda_pkg::ADDR_W,
  parameter int unsigned SAMPLE_W = adda_pkg::SAMPLE_W,
  parameter logic [SAMPLE_W-1:0] IDLE_CODE = SAMPLE_W'(adda_pkg::IDLE_CODE)
) (
  input  logic                  CLK32MHz,
  input  logic                  greset,
  input  logic                  start_rec,
  input  logic                  start_play,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_W:0]       rec_len,
  input  logic [SAMPLE_W-1:0]   ad,
  output logic [SAMPLE_W-1:0]   da,
  output logic                  busy,
  output logic [ADDR_W:0]       rec_words,
  output logic [ADDR_W-1:0]     ram_adr,
  output logic [2*SAMPLE_W-1:0] ram_dat_o,
  output logic                  ram_dat_oe,
  input  logic [2*SAMPLE_W-1:0] ram_dat_i,
  output logic                  ram_cs_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  ram_lb_n,
  output logic                  ram_ub_n
);
  import adda_pkg::*;

  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned WORD_W = 2 * SAMPLE_W;
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] FULL = PTR_W'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic                phase_q, phase_d;
  logic [SAMPLE_W-1:0] ad_q, ad_d;
  logic [SAMPLE_W-1:0] lo_q, lo_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                stop_q, stop_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   rd_q, rd_d;
  logic                rd_valid_q, rd_valid_d;
  logic [SAMPLE_W-1:0] da_q, da_d;
  logic                cs_n_q, cs_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                dat_oe_q, dat_oe_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [WORD_W-1:0]   dat_q, dat_d;
  logic [PTR_W-1:0]    rec_words_q, rec_words_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    limit;

  // State and output registers
  always_ff @(posedge CLK32MHz) begin
    if (greset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      ad_q        <= '0;
      lo_q        <= '0;
      ptr_q       <= '0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
      da_q        <= IDLE_CODE;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dat_oe_q    <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rec_words_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ad_q        <= ad_d;
      lo_q        <= lo_d;
      ptr_q       <= ptr_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      rd_valid_q  <= rd_valid_d;
      da_q        <= da_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dat_oe_q    <= dat_oe_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rec_words_q <= rec_words_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; outputs are computed one cycle ahead so every pin is a flop
  always_comb begin
    state_d     = state_q;
    phase_d     = ~phase_q;
    ad_d        = ad;
    lo_d        = lo_q;
    ptr_d       = ptr_q;
    stop_d      = stop_q;
    done_d      = done_q;
    rd_d        = rd_q;
    rd_valid_d  = rd_valid_q;
    da_d        = da_q;
    cs_n_d      = cs_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    dat_oe_d    = dat_oe_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rec_words_d = rec_words_q;
    busy_d      = busy_q;
    limit       = (rec_len == '0 || rec_len > FULL) ? FULL : rec_len;

    case (state_q)
      IDLE: begin
        phase_d = 1'b0;
        if (start_rec) begin
          state_d  = REC;
          ptr_d    = '0;
          stop_d   = 1'b0;
          done_d   = 1'b0;
          dat_oe_d = 1'b1;
          busy_d   = 1'b1;
        end else if (start_play && rec_words_q != '0) begin
          state_d    = PLAY;
          ptr_d      = '0;
          adr_d      = '0;
          cs_n_d     = 1'b0;
          oe_n_d     = 1'b0;
          done_d     = 1'b0;
          rd_valid_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      REC: begin
        if (stop) stop_d = 1'b1;
        if (!phase_q) begin
          lo_d   = ad_q;
          cs_n_d = 1'b1;
          we_n_d = 1'b1;
        end else if (done_q) begin
          // Last word has had its write cycle and its hold cycle
          state_d     = IDLE;
          rec_words_d = ptr_q;
        end else begin
          adr_d  = ptr_q[ADDR_W-1:0];
          dat_d  = {ad_q, lo_q};
          cs_n_d = 1'b0;
          we_n_d = 1'b0;
          ptr_d  = ptr_q + ONE;
          done_d = stop_q || stop || (ptr_q + ONE == limit);
        end
      end

      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!phase_q) begin
          if (rd_valid_q) da_d = rd_q[SAMPLE_W-1:0];
          else if (done_q) state_d = IDLE;
        end else begin
          if (rd_valid_q) da_d = rd_q[WORD_W-1:SAMPLE_W];
          rd_valid_d = !cs_n_q;
          if (!cs_n_q) begin
            rd_d = ram_dat_i;
            if (ptr_q == rec_words_q - ONE) begin
              if (loop_en) begin
                ptr_d = '0;
              end else begin
                cs_n_d = 1'b1;
                oe_n_d = 1'b1;
                done_d = 1'b1;
              end
            end else begin
              ptr_d = ptr_q + ONE;
            end
            adr_d = ptr_d[ADDR_W-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      da_d       = IDLE_CODE;
      cs_n_d     = 1'b1;
      oe_n_d     = 1'b1;
      we_n_d     = 1'b1;
      dat_oe_d   = 1'b0;
      adr_d      = '0;
      dat_d      = '0;
      busy_d     = 1'b0;
      rd_valid_d = 1'b0;
    end
  end

  assign da         = da_q;
  assign busy       = busy_q;
  assign rec_words  = rec_words_q;
  assign ram_adr    = adr_q;
  assign ram_dat_o  = dat_q;
  assign ram_dat_oe = dat_oe_q;
  assign ram_cs_n   = cs_n_q;
  assign ram_oe_n   = oe_n_q;
  assign ram_we_n   = we_n_q;
  assign ram_lb_n   = 1'b0;
  assign ram_ub_n   = 1'b0;

endmodule

// File: tb/tb_adda_sram_recorder.sv
// Directed bench for adda_sram_recorder with a behavioural async SRAM (10-unit tAA).
module tb_adda_sram_recorder;

  logic        clk = 1'b0;
  logic        greset, start_rec, start_play, stop, loop_en;
  logic [18:0] rec_len;
  logic [7:0]  ad, da;
  logic        busy;
  logic [18:0] rec_words;
  logic [17:0] ram_adr;
  logic [15:0] ram_dat_o, ram_dat_i;
  logic        ram_dat_oe, ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;

  logic [15:0] mem [0:(1<<18)-1];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          we_consec = 0;
  logic        we_prev = 1'b0;

  always #16 clk = ~clk;

  adda_sram_recorder dut (
    .CLK32MHz  (clk),
    .greset    (greset),
    .start_rec (start_rec),
    .start_play(start_play),
    .stop      (stop),
    .loop_en   (loop_en),
    .rec_len   (rec_len),
    .ad        (ad),
    .da        (da),
    .busy      (busy),
    .rec_words (rec_words),
    .ram_adr   (ram_adr),
    .ram_dat_o (ram_dat_o),
    .ram_dat_oe(ram_dat_oe),
    .ram_dat_i (ram_dat_i),
    .ram_cs_n  (ram_cs_n),
    .ram_oe_n  (ram_oe_n),
    .ram_we_n  (ram_we_n),
    .ram_lb_n  (ram_lb_n),
    .ram_ub_n  (ram_ub_n)
  );

  // SRAM read path: data valid tAA after the address/strobes change
  initial begin
    ram_dat_i = 16'h0000;
    forever begin
      @(posedge clk);
      #10;
      ram_dat_i = (!ram_cs_n && !ram_oe_n) ? mem[ram_adr] : 16'h0000;
    end
  end

  // SRAM write path and write-pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!ram_we_n) begin
        we_cnt = we_cnt + 1;
        if (we_prev) we_consec = we_consec + 1;
      end
      we_prev = !ram_we_n;
      if (!ram_cs_n && !ram_we_n && ram_dat_oe) mem[ram_adr] = ram_dat_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        srec;
    logic [7:0]  ad;
    logic        busy;
    logic        cs_n;
    logic        we_n;
    logic [17:0] adr;
    logic [15:0] dat;
  } rec_vec_t;

  rec_vec_t rv [11];

  initial begin
    int         we_base;
    logic [7:0] exp_da;
    logic       exp_busy;

    rv[0]  = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000};
    rv[1]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000};
    rv[2]  = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 18'd0, 16'h1110};
    rv[3]  = '{1'b0, 8'h13, 1'b1, 1'b1, 1'b1, 18'd0, 16'h1110};
    rv[4]  = '{1'b0, 8'h14, 1'b1, 1'b0, 1'b0, 18'd1, 16'h1312};
    rv[5]  = '{1'b0, 8'h15, 1'b1, 1'b1, 1'b1, 18'd1, 16'h1312};
    rv[6]  = '{1'b0, 8'h16, 1'b1, 1'b0, 1'b0, 18'd2, 16'h1514};
    rv[7]  = '{1'b0, 8'h17, 1'b1, 1'b1, 1'b1, 18'd2, 16'h1514};
    rv[8]  = '{1'b0, 8'h18, 1'b1, 1'b0, 1'b0, 18'd3, 16'h1716};
    rv[9]  = '{1'b0, 8'h19, 1'b1, 1'b1, 1'b1, 18'd3, 16'h1716};
    rv[10] = '{1'b0, 8'h1a, 1'b0, 1'b1, 1'b1, 18'd0, 16'h0000};

    greset = 1'b1; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0;
    loop_en = 1'b0; rec_len = 19'd0; ad = 8'h00;

    // Reset
    @(negedge clk);
    cyc(); cyc();
    check("rst cs_n", 32'(ram_cs_n), 32'd1);
    check("rst oe_n", 32'(ram_oe_n), 32'd1);
    check("rst we_n", 32'(ram_we_n), 32'd1);
    check("rst lb_ub", 32'({ram_lb_n, ram_ub_n}), 32'd0);
    check("rst dat_oe", 32'(ram_dat_oe), 32'd0);
    check("rst da", 32'(da), 32'h80);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rec_words", 32'(rec_words), 32'd0);
    check("rst adr", 32'(ram_adr), 32'd0);
    greset = 1'b0;
    cyc();

    // Record four words from a ramp
    rec_len = 19'd4;
    we_base = we_cnt;
    for (int i = 0; i < 11; i++) begin
      start_rec = rv[i].srec;
      ad = rv[i].ad;
      cyc();
      check($sformatf("rec%0d busy", i), 32'(busy), 32'(rv[i].busy));
      check($sformatf("rec%0d dat_oe", i), 32'(ram_dat_oe), 32'(rv[i].busy));
      check($sformatf("rec%0d cs_n", i), 32'(ram_cs_n), 32'(rv[i].cs_n));
      check($sformatf("rec%0d we_n", i), 32'(ram_we_n), 32'(rv[i].we_n));
      check($sformatf("rec%0d oe_n", i), 32'(ram_oe_n), 32'd1);
      check($sformatf("rec%0d adr", i), 32'(ram_adr), 32'(rv[i].adr));
      check($sformatf("rec%0d dat", i), 32'(ram_dat_o), 32'(rv[i].dat));
      check($sformatf("rec%0d da", i), 32'(da), 32'h80);
    end
    start_rec = 1'b0;
    cyc();
    check("rec rec_words", 32'(rec_words), 32'd4);
    check("rec mem0", 32'(mem[0]), 32'h1110);
    check("rec mem1", 32'(mem[1]), 32'h1312);
    check("rec mem2", 32'(mem[2]), 32'h1514);
    check("rec mem3", 32'(mem[3]), 32'h1716);
    check("rec we pulses", 32'(we_cnt - we_base), 32'd4);
    check("rec we consecutive", 32'(we_consec), 32'd0);

    // Play once; a start_rec while busy must be ignored
    for (int c = 0; c < 12; c++) begin
      start_play = (c == 0);
      start_rec  = (c == 5);
      cyc();
      exp_da   = (c >= 3 && c <= 10) ? 8'(8'h10 + c - 3) : 8'h80;
      exp_busy = (c <= 10);
      check($sformatf("play%0d da", c), 32'(da), 32'(exp_da));
      check($sformatf("play%0d busy", c), 32'(busy), 32'(exp_busy));
      check($sformatf("play%0d dat_oe", c), 32'(ram_dat_oe), 32'd0);
      check($sformatf("play%0d we_n", c), 32'(ram_we_n), 32'd1);
      if (c == 0) check("play0 oe_n", 32'(ram_oe_n), 32'd0);
      if (c == 0) check("play0 cs_n", 32'(ram_cs_n), 32'd0);
      if (c == 2) check("play2 adr", 32'(ram_adr), 32'd1);
    end
    start_play = 1'b0; start_rec = 1'b0;
    cyc();

    // Looped play; loop_en cleared during the second pass
    loop_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      start_play = (c == 0);
      if (c == 10) loop_en = 1'b0;
      cyc();
      exp_da   = (c >= 3 && c <= 18) ? 8'(8'h10 + ((c - 3) % 8)) : 8'h80;
      exp_busy = (c <= 18);
      check($sformatf("loop%0d da", c), 32'(da), 32'(exp_da));
      check($sformatf("loop%0d busy", c), 32'(busy), 32'(exp_busy));
    end
    start_play = 1'b0;
    cyc();

    // Stop while s[4] is held: pair (s4,s5) still lands as word 2
    rec_len = 19'd0;
    we_base = we_cnt;
    for (int i = 0; i < 10; i++) begin
      start_rec = (i == 0);
      stop      = (i == 5);
      ad        = 8'(8'h20 + i);
      cyc();
      check($sformatf("stop%0d busy", i), 32'(busy), 32'(i <= 7));
    end
    start_rec = 1'b0; stop = 1'b0;
    cyc();
    check("stop rec_words", 32'(rec_words), 32'd3);
    check("stop mem0", 32'(mem[0]), 32'h2120);
    check("stop mem1", 32'(mem[1]), 32'h2322);
    check("stop mem2", 32'(mem[2]), 32'h2524);
    check("stop mem3 untouched", 32'(mem[3]), 32'h1716);
    check("stop we pulses", 32'(we_cnt - we_base), 32'd3);

    // Reset in the middle of playback
    start_play = 1'b1;
    cyc();
    start_play = 1'b0;
    cyc(); cyc();
    check("midplay cs_n before reset", 32'(ram_cs_n), 32'd0);
    greset = 1'b1;
    cyc();
    check("midplay reset cs_n", 32'(ram_cs_n), 32'd1);
    check("midplay reset oe_n", 32'(ram_oe_n), 32'd1);
    check("midplay reset busy", 32'(busy), 32'd0);
    check("midplay reset da", 32'(da), 32'h80);
    check("midplay reset rec_words", 32'(rec_words), 32'd0);
    greset = 1'b0;
    cyc();

    // start_play with nothing recorded is ignored
    start_play = 1'b1;
    cyc();
    start_play = 1'b0;
    check("empty play busy", 32'(busy), 32'd0);
    check("empty play cs_n", 32'(ram_cs_n), 32'd1);
    cyc();
    check("empty play busy later", 32'(busy), 32'd0);

    // Simultaneous starts select recording
    rec_len = 19'd4;
    start_rec = 1'b1; start_play = 1'b1; ad = 8'h55;
    cyc();
    start_rec = 1'b0; start_play = 1'b0;
    check("both busy", 32'(busy), 32'd1);
    check("both dat_oe", 32'(ram_dat_oe), 32'd1);
    check("both oe_n", 32'(ram_oe_n), 32'd1);
    stop = 1'b1; ad = 8'h66;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("both end busy", 32'(busy), 32'd0);
    check("both rec_words", 32'(rec_words), 32'd1);
    check("both mem0", 32'(mem[0]), 32'h6655);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
